mux_scan_nto1: RTL

Parametrised N-channel, W-bit multiplexer with a registered output, valid/ready output handshake and an autonomous scan mode that sweeps all channels with a programmable per-channel dwell. It generalises the fixed 16:1 single-bit selector into the data-path front end that feeds serial/readout logic one channel at a time. Static mode behaves as a one-cycle-latency registered mux; scan mode is sequenced by an internal FSM.

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_nto1_comb.sv | 24 ++
 rtl/mux_scan_nto1.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanning N:1 multiplexer.
// Used by mux_nto1_comb and mux_scan_nto1.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        HOLD  = 2'd2
    } scan_state_t;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Channel-index width; a two-channel mux still needs one select bit.
    function automatic int f_ch_w(input int n_ch);
        return (n_ch <= 2) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/mux_nto1_comb.sv
// Combinational N:1 word selector.
// A select at or above N_CH yields all-zero data.
module mux_nto1_comb
    import mux_pkg::*;
#(
    parameter  int N_CH   = 16,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = f_ch_w(N_CH)
) (
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]       sel,
    output logic [DATA_W-1:0]      out_data
);

    always_comb begin
        out_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                out_data = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mux_scan_nto1.sv
// N-channel registered mux with valid/ready output and an autonomous channel scan.
// Optional MUX_SCAN_MASK_EN adds ch_mask to restrict the scan to selected channels.
//
// state | meaning
// IDLE  | static mux (mode=0) or waiting for start (mode=1)
// DWELL | counting dwell cycles before capturing channel ch_ptr
// HOLD  | captured word presented, waiting for out_ready
module mux_scan_nto1
    import mux_pkg::*;
#(
    parameter  int N_CH    = 16,
    parameter  int DATA_W  = 8,
    parameter  int DWELL_W = 8,
    localparam int CH_W    = f_ch_w(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic                     mode,
    input  logic [CH_W-1:0]          sel,
    input  logic [DWELL_W-1:0]       dwell,
    input  logic                     start,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
`ifdef MUX_SCAN_MASK_EN
    ,
    input  logic [N_CH-1:0]          ch_mask
`endif
);

    scan_state_t         r_state, w_state_nxt;
    logic [CH_W-1:0]     r_ch_ptr, w_ch_ptr_nxt;
    logic [DWELL_W-1:0]  r_dwell_cnt, w_dwell_nxt;
    logic [DATA_W-1:0]   r_out_data, w_data_nxt;
    logic [CH_W-1:0]     r_out_ch, w_och_nxt;
    logic                r_out_valid, w_valid_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic [N_CH-1:0]     r_mask, w_mask_nxt;

    logic [N_CH-1:0]     w_mask_in;
    logic [CH_W-1:0]     w_mux_sel;
    logic [DATA_W-1:0]   w_mux_data;
    logic                w_slot_free;
    logic                w_first_ok, w_next_ok;
    logic [CH_W-1:0]     w_first_ch, w_next_ch;

`ifdef MUX_SCAN_MASK_EN
    assign w_mask_in = ch_mask;
`else
    assign w_mask_in = '1;
`endif

    assign w_mux_sel   = (r_state == IDLE) ? sel : r_ch_ptr;
    assign w_slot_free = !r_out_valid || out_ready;

    mux_nto1_comb #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W)
    ) u_mux (
        .in_data  (in_data),
        .sel      (w_mux_sel),
        .out_data (w_mux_data)
    );

    // First channel comes from the live mask; successors from the mask frozen at start.
    always_comb begin
        w_first_ok = 1'b0;
        w_first_ch = '0;
        w_next_ok  = 1'b0;
        w_next_ch  = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_mask_in[k]) begin
                w_first_ok = 1'b1;
                w_first_ch = CH_W'(k);
            end
            if (r_mask[k] && (CH_W'(k) > r_ch_ptr)) begin
                w_next_ok = 1'b1;
                w_next_ch = CH_W'(k);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ch_ptr_nxt = r_ch_ptr;
        w_dwell_nxt  = r_dwell_cnt;
        w_data_nxt   = r_out_data;
        w_och_nxt    = r_out_ch;
        w_valid_nxt  = r_out_valid;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_mask_nxt   = r_mask;
        case (r_state)
            IDLE: begin
                if (mode == MODE_STATIC) begin
                    if (w_slot_free) begin
                        w_data_nxt  = w_mux_data;
                        w_och_nxt   = sel;
                        w_valid_nxt = 1'b1;
                    end
                end else begin
                    if (r_out_valid && out_ready) begin
                        w_valid_nxt = 1'b0;
                    end
                    if (start && w_slot_free && w_first_ok) begin
                        w_state_nxt  = DWELL;
                        w_ch_ptr_nxt = w_first_ch;
                        w_dwell_nxt  = dwell;
                        w_busy_nxt   = 1'b1;
                        w_mask_nxt   = w_mask_in;
                    end
                end
            end
            DWELL: begin
                if (r_dwell_cnt == '0) begin
                    w_data_nxt  = w_mux_data;
                    w_och_nxt   = r_ch_ptr;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = HOLD;
                end else begin
                    w_dwell_nxt = r_dwell_cnt - DWELL_W'(1);
                end
            end
            HOLD: begin
                if (r_out_valid && out_ready) begin
                    w_valid_nxt = 1'b0;
                    if (w_next_ok) begin
                        w_ch_ptr_nxt = w_next_ch;
                        w_dwell_nxt  = dwell;
                        w_state_nxt  = DWELL;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ch_ptr    <= '0;
            r_dwell_cnt <= '0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mask      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ch_ptr    <= w_ch_ptr_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            r_out_data  <= w_data_nxt;
            r_out_ch    <= w_och_nxt;
            r_out_valid <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_mask      <= w_mask_nxt;
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
